cordic_shift_sched: RTL

- Parametrised run-time generator of the CORDIC shift-amount schedule; replaces fixed per-iteration shift ROMs.
- Produces one shift amount per consumed step for hyperbolic mode (repeats at k = 4, 13, 40, ...) or circular mode (no repeats).
- Sits between the CORDIC control FSM and the X/Y barrel shifters and atanh/atan table address.
- Adds a start/advance/done handshake and a run-time iteration count.

---
 rtl/cordic_pkg.sv | 20 ++
 rtl/cordic_repeat_track.sv | 47 ++++
 rtl/cordic_shift_sched.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC shift-schedule generator: mode codes,
// FSM state encoding and the first hyperbolic repeat index.
package cordic_pkg;

   // MODE input encoding
   localparam logic MODE_HYP  = 1'b0;
   localparam logic MODE_CIRC = 1'b1;

   // First shift amount that is issued twice in hyperbolic mode; later
   // repeat points follow k <= 3k+1 (4, 13, 40, 121, ...).
   localparam int FIRST_REPEAT = 4;

   // Scheduler FSM states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIN  = 2'd2
   } state_t;

endpackage

// File: rtl/cordic_repeat_track.sv
// Tracks the next hyperbolic repeat point (nr) and decides whether the
// step about to be issued must reuse the current shift amount.
module cordic_repeat_track
   import cordic_pkg::*;
#(
   parameter int P = 5
) (
   input  logic         clk,
   input  logic         srst,
   input  logic         init,         // new schedule accepted: rewind nr
   input  logic         step,         // a non-final step is being consumed
   input  logic         mode,         // latched schedule mode
   input  logic         repeat_cur,   // current step already is a repeat
   input  logic [P-1:0] shift,        // current shift amount
   output logic         take_repeat   // next step reissues the same shift
);

   // nr is kept two bits wider than SHIFT so the 3k+1 sequence can run past
   // the largest shift without wrapping back into the shift range.
   localparam int NRW = P + 2;
   localparam logic [NRW-1:0] NR_FIRST  = NRW'(FIRST_REPEAT);
   localparam logic [P-1:0]   SHIFT_MAX = '1;

   logic [NRW-1:0] nr_reg;
   logic [NRW-1:0] nr_next;
   logic [NRW+1:0] nr_x3p1;

   // Repeat decision and saturating 3k+1 update of the repeat point
   always_comb begin
      nr_x3p1 = ({2'b00, nr_reg} << 1) + {2'b00, nr_reg} + (NRW + 2)'(1);
      nr_next = (nr_x3p1[NRW+1:NRW] != 2'b00) ? '1 : nr_x3p1[NRW-1:0];
      // A saturated shift never triggers a repeat, otherwise the held
      // maximum would alternate between plain and repeated steps.
      take_repeat = (mode == MODE_HYP) && !repeat_cur &&
                    (shift != SHIFT_MAX) && ({2'b00, shift} == nr_reg);
   end

   // nr register: rewound on reset or a new schedule, advanced on each repeat
   always_ff @(posedge clk) begin
      if (srst || init) begin
         nr_reg <= NR_FIRST;
      end else if (step && take_repeat) begin
         nr_reg <= nr_next;
      end
   end

endmodule

// File: rtl/cordic_shift_sched.sv
// Run-time CORDIC shift-amount schedule generator. Issues one shift per
// consumed step (VALID && ADV), with hyperbolic repeats at 4, 13, 40, ...
// and a start/advance/done handshake. All outputs are registered.
module cordic_shift_sched
   import cordic_pkg::*;
#(
   parameter int P   = 5,
   parameter int N_W = 6
) (
   input  logic           CLK,
   input  logic           RST,
   input  logic           START,
   input  logic           MODE,
   input  logic [N_W-1:0] N_ITER,
   input  logic           ADV,
   output logic           BUSY,
   output logic           VALID,
   output logic [P-1:0]   SHIFT,
   output logic [N_W-1:0] ITER,
   output logic           REPEAT,
   output logic           LAST,
   output logic           DONE
);

   localparam logic [P-1:0]   SHIFT_MAX  = '1;
   localparam logic [N_W:0]   ITER_STEP2 = (N_W + 1)'(2);

   state_t         state_reg,  state_next;
   logic           mode_reg,   mode_next;
   logic [N_W-1:0] n_reg,      n_next;
   logic           busy_reg,   busy_next;
   logic           valid_reg,  valid_next;
   logic [P-1:0]   shift_reg,  shift_next;
   logic [N_W-1:0] iter_reg,   iter_next;
   logic           repeat_reg, repeat_next;
   logic           last_reg,   last_next;
   logic           done_reg,   done_next;

   logic           nr_init;
   logic           nr_step;
   logic           take_repeat;

   cordic_repeat_track #(
      .P (P)
   ) u_repeat (
      .clk         (CLK),
      .srst        (RST),
      .init        (nr_init),
      .step        (nr_step),
      .mode        (mode_reg),
      .repeat_cur  (repeat_reg),
      .shift       (shift_reg),
      .take_repeat (take_repeat)
   );

   // State and output registers; reset clears everything, dropping a pending DONE
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_reg  <= ST_IDLE;
         mode_reg   <= MODE_HYP;
         n_reg      <= '0;
         busy_reg   <= 1'b0;
         valid_reg  <= 1'b0;
         shift_reg  <= '0;
         iter_reg   <= '0;
         repeat_reg <= 1'b0;
         last_reg   <= 1'b0;
         done_reg   <= 1'b0;
      end else begin
         state_reg  <= state_next;
         mode_reg   <= mode_next;
         n_reg      <= n_next;
         busy_reg   <= busy_next;
         valid_reg  <= valid_next;
         shift_reg  <= shift_next;
         iter_reg   <= iter_next;
         repeat_reg <= repeat_next;
         last_reg   <= last_next;
         done_reg   <= done_next;
      end
   end

   // Next-state and next-output logic; step data holds unless a step is consumed
   always_comb begin
      state_next  = state_reg;
      mode_next   = mode_reg;
      n_next      = n_reg;
      valid_next  = valid_reg;
      shift_next  = shift_reg;
      iter_next   = iter_reg;
      repeat_next = repeat_reg;
      last_next   = last_reg;
      done_next   = 1'b0;
      nr_init     = 1'b0;
      nr_step     = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            if (START) begin
               mode_next = MODE;
               n_next    = N_ITER;
               nr_init   = 1'b1;
               if (N_ITER != '0) begin
                  state_next  = ST_RUN;
                  valid_next  = 1'b1;
                  iter_next   = '0;
                  shift_next  = (MODE == MODE_HYP) ? P'(1) : '0;
                  repeat_next = 1'b0;
                  last_next   = (N_ITER == N_W'(1));
               end else begin
                  // Empty schedule: no steps, just the completion pulse
                  state_next = ST_FIN;
               end
            end
         end

         ST_RUN: begin
            if (valid_reg && ADV) begin
               if (last_reg) begin
                  state_next = ST_FIN;
                  valid_next = 1'b0;
                  last_next  = 1'b0;
               end else begin
                  nr_step   = 1'b1;
                  iter_next = iter_reg + N_W'(1);
                  // Next step is the last when iter+1 == n-1
                  last_next = (({1'b0, iter_reg} + ITER_STEP2) == {1'b0, n_reg});
                  if (take_repeat) begin
                     repeat_next = 1'b1;
                  end else begin
                     repeat_next = 1'b0;
                     shift_next  = (shift_reg == SHIFT_MAX) ? shift_reg
                                                            : shift_reg + P'(1);
                  end
               end
            end
         end

         ST_FIN: begin
            state_next = ST_IDLE;
            done_next  = 1'b1;
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase

      // BUSY covers RUN and FIN, so it falls in the same cycle DONE rises
      busy_next = (state_next != ST_IDLE);
   end

   assign BUSY   = busy_reg;
   assign VALID  = valid_reg;
   assign SHIFT  = shift_reg;
   assign ITER   = iter_reg;
   assign REPEAT = repeat_reg;
   assign LAST   = last_reg;
   assign DONE   = done_reg;

endmodule
